// File: rtl/axi_sts_sticky_register_if.sv
// AXI4-Lite bus bundle for the status/sticky register block.
interface axi_sts_sticky_register_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_sts_sticky_register.sv
// AXI4-Lite slave: wide live status bus (optional coherent snapshot on word 0)
// plus write-1-to-clear sticky event flags.
module axi_sts_sticky_register #(
    parameter int STS_DATA_WIDTH = 1024,
    parameter int STK_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int SNAPSHOT       = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [STS_DATA_WIDTH-1:0] sts_data,
    input  logic [STK_DATA_WIDTH-1:0] evt_in,
    output logic [STK_DATA_WIDTH-1:0] stk_flags,
    axi_sts_sticky_register_if.slave  s_axi
);
    localparam int W        = AXI_DATA_WIDTH;
    localparam int NS       = STS_DATA_WIDTH / W;
    localparam int NK       = (STK_DATA_WIDTH + W - 1) / W;
    localparam int NW       = NS + NK;
    localparam int ADDR_LSB = 2;
    localparam int IDXW     = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [STK_DATA_WIDTH-1:0] flags_q;
    logic [STS_DATA_WIDTH-1:0] shadow_q;
    logic [NK*W-1:0]           stk_pad;
    logic [NK*W-1:0]           clr_pad;

    logic            rd_vld_p1, wr_vld_p1;
    logic [W-1:0]    rd_data_p1;
    logic [1:0]      rd_resp_p1, wr_resp_p1;

    logic            ar_hs, wr_hs;
    logic [IDXW-1:0] rd_idx, wr_idx;
    logic [W-1:0]    rd_word, wr_mask;
    logic            rd_err, wr_ok;
    logic            unused_bits;

    assign rd_idx = s_axi.araddr[ADDR_LSB +: IDXW];
    assign wr_idx = s_axi.awaddr[ADDR_LSB +: IDXW];

    // One read in flight; AW and W are only ever taken together.
    assign ar_hs = s_axi.arvalid & ~rd_vld_p1;
    assign wr_hs = aresetn & s_axi.awvalid & s_axi.wvalid & ~wr_vld_p1;

    assign s_axi.arready = ~rd_vld_p1;
    assign s_axi.awready = wr_hs;
    assign s_axi.wready  = wr_hs;
    assign s_axi.rvalid  = rd_vld_p1;
    assign s_axi.rdata   = rd_data_p1;
    assign s_axi.rresp   = rd_resp_p1;
    assign s_axi.bvalid  = wr_vld_p1;
    assign s_axi.bresp   = wr_resp_p1;
    assign stk_flags     = flags_q;

    always_comb begin
        stk_pad = '0;
        stk_pad[STK_DATA_WIDTH-1:0] = flags_q;
    end

    // Word 0 always reads live; with SNAPSHOT the other status words come from the shadow.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (rd_idx == IDXW'(i)) begin
                rd_err  = 1'b0;
                rd_word = (SNAPSHOT != 0 && i != 0) ? shadow_q[i*W +: W] : sts_data[i*W +: W];
            end
        end
        for (int k = 0; k < NK; k++) begin
            if (rd_idx == IDXW'(NS + k)) begin
                rd_err  = 1'b0;
                rd_word = stk_pad[k*W +: W];
            end
        end
    end

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < W/8; b++) begin
            wr_mask[b*8 +: 8] = s_axi.wdata[b*8 +: 8] & {8{s_axi.wstrb[b]}};
        end
        clr_pad = '0;
        wr_ok   = 1'b0;
        for (int k = 0; k < NK; k++) begin
            if (wr_idx == IDXW'(NS + k)) begin
                wr_ok = 1'b1;
                if (wr_hs) begin
                    clr_pad[k*W +: W] = wr_mask;
                end
            end
        end
    end

    assign unused_bits = ^{s_axi.araddr, s_axi.awaddr, clr_pad};

    // Stage 1: registered read/write responses and sticky/shadow state
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
            rd_resp_p1 <= RESP_OKAY;
            wr_vld_p1  <= 1'b0;
            wr_resp_p1 <= RESP_OKAY;
            flags_q    <= '0;
            shadow_q   <= '0;
        end else begin
            flags_q <= (flags_q & ~clr_pad[STK_DATA_WIDTH-1:0]) | evt_in;

            if (ar_hs) begin
                rd_vld_p1  <= 1'b1;
                rd_data_p1 <= rd_word;
                rd_resp_p1 <= rd_err ? RESP_SLVERR : RESP_OKAY;
                if (SNAPSHOT != 0 && rd_idx == '0) begin
                    shadow_q <= sts_data;
                end
            end else if (s_axi.rready) begin
                rd_vld_p1 <= 1'b0;
            end

            if (wr_hs) begin
                wr_vld_p1  <= 1'b1;
                wr_resp_p1 <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi.bready) begin
                wr_vld_p1 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_sts_sticky_register.sv
// Directed bench for axi_sts_sticky_register: vector table plus handshake corner cases.
module tb_axi_sts_sticky_register;
    logic          aclk = 1'b0;
    logic          aresetn;
    logic [1023:0] sts;
    logic [31:0]   evt;
    logic [31:0]   flags0, flags1;
    int            n_cmp = 0;
    int            n_bad = 0;

    axi_sts_sticky_register_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) axi0 ();
    axi_sts_sticky_register_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) axi1 ();

    axi_sts_sticky_register #(.SNAPSHOT(1)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .sts_data(sts), .evt_in(evt),
        .stk_flags(flags0), .s_axi(axi0)
    );

    axi_sts_sticky_register #(.SNAPSHOT(0)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .sts_data(sts), .evt_in(evt),
        .stk_flags(flags1), .s_axi(axi1)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] sts0;
        logic [31:0] sts1;
        logic [31:0] evt_pre;
        logic [31:0] evt_co;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl [0:18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no handshake within 20 cycles", nm);
    endtask

    task automatic pulse(input logic [31:0] e);
        @(negedge aclk);
        evt = e;
        @(negedge aclk);
        evt = '0;
    endtask

    task automatic axi_read(input bit u, input logic [15:0] a,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge aclk);
        if (u) begin axi1.araddr = a; axi1.arvalid = 1'b1; end
        else   begin axi0.araddr = a; axi0.arvalid = 1'b1; end
        n = 0;
        while ((u ? axi1.arready : axi0.arready) !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        if (u) axi1.arvalid = 1'b0; else axi0.arvalid = 1'b0;
        n = 0;
        while ((u ? axi1.rvalid : axi0.rvalid) !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) timeout("rd_timeout");
        d = u ? axi1.rdata : axi0.rdata;
        r = u ? axi1.rresp : axi0.rresp;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] e, output logic [1:0] r);
        int n;
        @(negedge aclk);
        axi0.awaddr = a; axi0.wdata = d; axi0.wstrb = s;
        axi0.awvalid = 1'b1; axi0.wvalid = 1'b1;
        evt = e;
        #1;
        n = 0;
        while (axi0.awready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            #1;
            n++;
        end
        @(negedge aclk);
        axi0.awvalid = 1'b0; axi0.wvalid = 1'b0;
        evt = '0;
        n = 0;
        while (axi0.bvalid !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) timeout("wr_timeout");
        r = axi0.bresp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d0;
        logic [1:0]  r;

        //            wr  addr      wdata         strb  sts0   sts1   evt_pre        evt_co   exp_data       resp
        tbl[0]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h1, 32'hA, 32'h0,         32'h0,   32'h1,         2'd0};
        tbl[1]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'hA,         2'd0};
        tbl[2]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'h1,         2'd0};
        tbl[3]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'hB,         2'd0};
        tbl[4]  = '{1'b0, 16'h0080, 32'h0,        4'h0, 32'h1, 32'hB, 32'h8,         32'h0,   32'h8,         2'd0};
        tbl[5]  = '{1'b1, 16'h0080, 32'h8,        4'h1, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd0};
        tbl[6]  = '{1'b0, 16'h0080, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd0};
        tbl[7]  = '{1'b0, 16'h0080, 32'h0,        4'h0, 32'h1, 32'hB, 32'h20,        32'h0,   32'h20,        2'd0};
        tbl[8]  = '{1'b1, 16'h0080, 32'h20,       4'h1, 32'h1, 32'hB, 32'h0,         32'h20,  32'h0,         2'd0};
        tbl[9]  = '{1'b0, 16'h0080, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'h20,        2'd0};
        tbl[10] = '{1'b1, 16'h0080, 32'h20,       4'h1, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd0};
        tbl[11] = '{1'b0, 16'h0080, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd0};
        tbl[12] = '{1'b1, 16'h0080, 32'hFF00,     4'h1, 32'h1, 32'hB, 32'h100,       32'h0,   32'h0,         2'd0};
        tbl[13] = '{1'b0, 16'h1080, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'h100,       2'd0};
        tbl[14] = '{1'b1, 16'h0080, 32'hFFFFFFFF, 4'hF, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd0};
        tbl[15] = '{1'b0, 16'h0084, 32'h0,        4'h0, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd2};
        tbl[16] = '{1'b1, 16'h0000, 32'hFFFFFFFF, 4'hF, 32'h1, 32'hB, 32'h0,         32'h0,   32'h0,         2'd2};
        tbl[17] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h5, 32'hB, 32'h0,         32'h0,   32'h5,         2'd0};
        tbl[18] = '{1'b0, 16'h0080, 32'h0,        4'h0, 32'h5, 32'hB, 32'h80000000,  32'h0,   32'h80000000,  2'd0};

        sts = '0;
        evt = '0;
        aresetn = 1'b0;
        axi0.awaddr = '0; axi0.awvalid = 1'b0; axi0.wdata = '0; axi0.wstrb = '0; axi0.wvalid = 1'b0;
        axi0.bready = 1'b1; axi0.araddr = '0; axi0.arvalid = 1'b1; axi0.rready = 1'b1;
        axi1.awaddr = '0; axi1.awvalid = 1'b0; axi1.wdata = '0; axi1.wstrb = '0; axi1.wvalid = 1'b0;
        axi1.bready = 1'b1; axi1.araddr = '0; axi1.arvalid = 1'b1; axi1.rready = 1'b1;

        // Reset held two cycles while a read is requested
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rvalid",  {31'b0, axi0.rvalid},  32'h0);
        chk("rst_bvalid",  {31'b0, axi0.bvalid},  32'h0);
        chk("rst_arready", {31'b0, axi0.arready}, 32'h1);
        chk("rst_awready", {31'b0, axi0.awready}, 32'h0);
        chk("rst_flags",   flags0,                32'h0);
        chk("rst_rdata",   axi0.rdata,            32'h0);
        chk("rst_rvalid1", {31'b0, axi1.rvalid},  32'h0);
        axi0.arvalid = 1'b0;
        axi1.arvalid = 1'b0;
        aresetn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            sts[31:0]  = tbl[i].sts0;
            sts[63:32] = tbl[i].sts1;
            if (tbl[i].evt_pre != 32'h0) pulse(tbl[i].evt_pre);
            if (tbl[i].is_wr) begin
                axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].evt_co, r);
                chk($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, tbl[i].exp_resp});
            end else begin
                axi_read(1'b0, tbl[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, tbl[i].exp_resp});
            end
        end
        chk("flags_top_bit", flags0, 32'h80000000);

        // Read backpressure: response held, no new read accepted
        @(negedge aclk);
        sts[31:0] = 32'h12345678;
        axi0.rready = 1'b0;
        axi0.araddr = 16'h0000;
        axi0.arvalid = 1'b1;
        @(negedge aclk);
        axi0.araddr = 16'h0084;
        sts[31:0] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            chk($sformatf("bp_rdata%0d", c), axi0.rdata, 32'h12345678);
            chk($sformatf("bp_arready%0d", c), {31'b0, axi0.arready}, 32'h0);
        end
        chk("bp_rresp", {30'b0, axi0.rresp}, 32'h0);
        axi0.arvalid = 1'b0;
        axi0.rready = 1'b1;
        @(negedge aclk);
        chk("bp_rvalid_clr", {31'b0, axi0.rvalid}, 32'h0);

        // Write backpressure: second AW/W waits for bready
        @(negedge aclk);
        axi0.bready = 1'b0;
        axi0.awaddr = 16'h0000; axi0.wdata = 32'hFFFFFFFF; axi0.wstrb = 4'hF;
        axi0.awvalid = 1'b1; axi0.wvalid = 1'b1;
        #1;
        chk("bpw_awready_first", {31'b0, axi0.awready}, 32'h1);
        @(negedge aclk);
        axi0.awaddr = 16'h0080;
        #1;
        chk("bpw_bresp_first", {30'b0, axi0.bresp}, 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            #1;
            chk($sformatf("bpw_awready%0d", c), {31'b0, axi0.awready}, 32'h0);
            chk($sformatf("bpw_wready%0d", c), {31'b0, axi0.wready}, 32'h0);
            chk($sformatf("bpw_bvalid%0d", c), {31'b0, axi0.bvalid}, 32'h1);
        end
        chk("bpw_flags_held", flags0, 32'h80000000);
        @(negedge aclk);
        axi0.bready = 1'b1;
        @(negedge aclk);
        #1;
        chk("bpw_awready_second", {31'b0, axi0.awready}, 32'h1);
        @(negedge aclk);
        axi0.awvalid = 1'b0; axi0.wvalid = 1'b0;
        chk("bpw_bvalid_second", {31'b0, axi0.bvalid}, 32'h1);
        chk("bpw_bresp_second", {30'b0, axi0.bresp}, 32'h0);
        chk("bpw_flags_cleared", flags0, 32'h0);

        // Without snapshot, status words read live
        sts[63:32] = 32'hB;
        axi_read(1'b1, 16'h0004, d, r);
        chk("live_word1_b", d, 32'hB);
        sts[63:32] = 32'hC;
        axi_read(1'b1, 16'h0004, d, r);
        chk("live_word1_c", d, 32'hC);
        chk("live_rresp", {30'b0, r}, 32'h0);
        axi_read(1'b0, 16'h0004, d0, r);
        chk("snap_word1_held", d0, 32'hB);

        @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_sts_sticky_register.md
Name: axi_sts_sticky_register

Overview:
AXI4-Lite slave exposing a wide live status bus plus a bank of sticky event flags to the PS.
- Optional coherent snapshot: reading word 0 captures the whole status bus, so multi-word counters read consistently.
- Sticky flags latch single-cycle events from PL logic and are cleared by write-1-to-clear.
- Sits next to the control register block on the PS GP port interconnect; generalises the plain status register with protocol-correct handshakes, error responses and a write path.

Parameters:
STS_DATA_WIDTH, 1024, status bus width in bits; must be a multiple of AXI_DATA_WIDTH.
STK_DATA_WIDTH, 32, sticky flag count, 1..1024; the last sticky word is zero-padded above the top flag.
AXI_DATA_WIDTH, 32, AXI data width in bits; only 32 is supported.
AXI_ADDR_WIDTH, 16, AXI address width; must cover all words.
SNAPSHOT, 1, 1 = coherent snapshot on word-0 read; 0 = all status words read live.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
sts_data  in  STS_DATA_WIDTH  live status bits
evt_in  in  STK_DATA_WIDTH  event pulses; each high bit sets the matching sticky flag
stk_flags  out  STK_DATA_WIDTH  current sticky flag state, for interrupt logic
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Sizes: NS = STS_DATA_WIDTH/32; NK = ceil(STK_DATA_WIDTH/32).
- Word index = addr[ADDR_LSB+:IDXW], with ADDR_LSB = 2. Address bits above the index are ignored.
- Address map: index 0..NS-1 = status words; NS..NS+NK-1 = sticky words; any other index = unmapped.
- Reset (aresetn low at a clock edge): outputs and internal state go to:
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0;
  - sticky flags=0, snapshot shadow=0;
  - arready=1; awready=wready=0.
- Read channel:
  - arready = ~rvalid; at most one read outstanding.
  - Read accepted on arvalid & arready; rvalid rises the next cycle (latency 1).
  - rdata and rresp are registered and held stable while rvalid & ~rready.
  - rvalid clears on rready & rvalid.
  - Back-to-back reads need at least 2 cycles each.
- Read data:
  - Status word i, SNAPSHOT=0: sts_data slice i as sampled on the accept cycle.
  - SNAPSHOT=1, index 0: the shadow register loads the full sts_data on the accept cycle; rdata = slice 0 of that sample.
  - SNAPSHOT=1, index 1..NS-1: slice i of the shadow; the shadow is unchanged.
  - Shadow before the first word-0 read = 0.
  - Sticky words: the flag value before the accept-cycle update (pre-update value).
  - rresp is OKAY (0) for mapped words. Unmapped: rdata = 0, rresp = SLVERR (2).
- Write channel:
  - awready = wready = awvalid & wvalid & ~bvalid, asserted together for one cycle; AW and W are never accepted independently.
  - bvalid rises the cycle after accept and clears on bready & bvalid.
  - Sticky word: per byte with wstrb set, flags whose wdata bit is 1 clear; bresp = OKAY.
  - Status or unmapped word: no state change; bresp = SLVERR.
- Sticky update, every cycle: flag <= (flag & ~clr) | evt_in.
  - Set wins over clear in the same cycle.
  - Padding bits always read 0.
- stk_flags: registered flag state, no extra latency.
- A read and a write accepted in the same cycle are both legal. The read sees the pre-clear value.
- Reset mid-transaction: outstanding rvalid/bvalid drop at once; the master must re-issue.

Test Plan:
- Reset: aresetn=0 for 2 cycles with arvalid=1 -> rvalid=0, bvalid=0, arready=1, stk_flags=0.
- Snapshot: sts_data word0=0x1, word1=0xA; read 0x0 -> 0x1. Change word1 to 0xB, read 0x4 -> 0xA. Read 0x0 then 0x4 -> 0xB. With SNAPSHOT=0, read 0x4 returns the live 0xB.
- Sticky: pulse evt_in[3] one cycle, read sticky word (index NS) -> 0x8. Write 0x8 with wstrb=0x1 -> bresp=0, re-read -> 0x0.
- Set beats clear: evt_in[5]=1 in the same cycle as a W1C of 0x20 -> flag stays 1; read returns 0x20.
- Errors: read at index NS+NK -> rdata=0, rresp=2. Write to status word 0 -> bresp=2, status reads unchanged.
- Backpressure: hold rready=0 for 5 cycles after a read -> rdata stable, arready=0 throughout. Hold bready=0 -> no new AW/W accepted.
